pipe_sel_mux: RTL and testbench

PIPE_SEL_MUX -- requirements
Module: pipe_sel_mux

---
 rtl/pipe_sel_mux_pkg.sv | 14 +
 rtl/pipe_sel_mux_if.sv | 38 +++
 rtl/pipe_sel_mux_skid_reg.sv | 99 +++++++++
 rtl/pipe_sel_mux.sv | 58 +++++
 tb/tb_pipe_sel_mux.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_sel_mux_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared constants for the pipelined select mux: default data width, default
// number of selectable inputs, and the word driven for an out-of-range select.
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_NUM_IN = 3;

    // Data word delivered when the select does not name an existing input.
    localparam logic [DEFAULT_WIDTH-1:0] ZERO_WORD = '0;

endpackage : pipe_pkg

// File: rtl/pipe_sel_mux_if.sv
// -----------------------------------------------------------------------------
// pipe_sel_mux_if
// Upstream offer and downstream result of pipe_sel_mux, as one bundle.
//   in_data     : NUM_IN*WIDTH flattened inputs, input k at [k*WIDTH +: WIDTH]
//   in_sel      : select, sampled together with in_data
//   in_valid    : upstream offer
//   in_ready    : mux can accept this cycle (registered)
//   out_data    : registered selected word
//   out_sel_err : select of this entry was out of range
//   out_valid   : out_data / out_sel_err are valid
//   out_ready   : downstream accepts
// master = the environment driving the mux, slave = the mux itself.
// -----------------------------------------------------------------------------
interface pipe_sel_mux_if import pipe_pkg::*; #(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NUM_IN = DEFAULT_NUM_IN,
    parameter int SEL_W  = $clog2(NUM_IN)
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_sel_err;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel_err, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_sel_err, out_valid
    );

endinterface : pipe_sel_mux_if

// File: rtl/pipe_sel_mux_skid_reg.sv
// -----------------------------------------------------------------------------
// skid_reg
// Two-entry skid buffer (main + skid register), strict FIFO order, with a
// registered ready that never depends combinationally on the downstream ready.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset, beats flush and all transfers
//   flush_i  : drop both entries, beats a simultaneous input transfer
//   data_i   : W-bit payload offered upstream
//   valid_i  : upstream offer
//   ready_o  : registered, equal to !skid_valid
//   data_o   : payload in the main register
//   valid_o  : main register holds an entry
//   ready_i  : downstream accepts
// -----------------------------------------------------------------------------
module skid_reg #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic [W-1:0] data_i,
    input  logic         valid_i,
    output logic         ready_o,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    input  logic         ready_i
);

    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         ready_q;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = valid_i && ready_q;
    assign out_xfer = main_valid_q && ready_i;

    always_comb begin
        // NOTE: every next-state value gets its hold value first, so no path
        // through the branches below can leave one unassigned (no latches).
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_xfer) begin
            // Main is free this cycle: the older skid entry goes first.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = in_xfer;
                if (in_xfer) begin
                    skid_d = data_i;
                end
            end else begin
                main_valid_d = in_xfer;
                if (in_xfer) begin
                    main_d = data_i;
                end
            end
        end else if (in_xfer) begin
            // Main is stalled: park the new entry in skid.
            skid_d       = data_i;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data registers are reset along with the valids because
            // out_data must read zero and the skid contents must be zero after
            // reset; pure storage would not normally need this.
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, whatever the statement order.
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= !skid_valid_d;
        end
    end

    assign ready_o = ready_q;
    assign data_o  = main_q;
    assign valid_o = main_valid_q;

endmodule : skid_reg

// File: rtl/pipe_sel_mux.sv
// -----------------------------------------------------------------------------
// pipe_sel_mux
// Selects one of NUM_IN WIDTH-bit inputs and delivers it one cycle later
// through a two-entry skid buffer. An out-of-range select yields a zero word
// with out_sel_err set.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   flush : synchronous discard of all buffered entries
//   bus   : slave side of pipe_sel_mux_if (in_data/in_sel/in_valid/in_ready,
//           out_data/out_sel_err/out_valid/out_ready)
// -----------------------------------------------------------------------------
module pipe_sel_mux import pipe_pkg::*; #(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NUM_IN = DEFAULT_NUM_IN,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    pipe_sel_mux_if.slave  bus
);

    logic [WIDTH-1:0] sel_word;
    logic             sel_err;
    logic [WIDTH:0]   buf_out;

    // Start from the out-of-range result; a matching select overrides it.
    // Select codes >= NUM_IN never match, so they keep the error result.
    always_comb begin
        sel_word = WIDTH'(ZERO_WORD);
        sel_err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                sel_word = bus.in_data[k*WIDTH +: WIDTH];
                sel_err  = 1'b0;
            end
        end
    end

    // Error flag travels as the MSB of the buffered payload.
    skid_reg #(
        .W (WIDTH + 1)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .data_i  ({sel_err, sel_word}),
        .valid_i (bus.in_valid),
        .ready_o (bus.in_ready),
        .data_o  (buf_out),
        .valid_o (bus.out_valid),
        .ready_i (bus.out_ready)
    );

    assign bus.out_data    = buf_out[WIDTH-1:0];
    assign bus.out_sel_err = buf_out[WIDTH];

endmodule : pipe_sel_mux

// File: tb/tb_pipe_sel_mux.sv
// -----------------------------------------------------------------------------
// tb_pipe_sel_mux
// Self-checking bench for pipe_sel_mux (WIDTH=32, NUM_IN=3). Inputs are driven
// and outputs sampled 1 time unit after each rising edge. Accepted entries are
// pushed as expected {err, data} onto a scoreboard queue and popped when the
// DUT presents them with out_ready high.
// -----------------------------------------------------------------------------
module tb_pipe_sel_mux;
    import pipe_pkg::*;

    localparam int W = 32;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    pipe_sel_mux_if #(.WIDTH(W), .NUM_IN(N)) bus ();

    pipe_sel_mux #(.WIDTH(W), .NUM_IN(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [W:0] sb_q[$];

    // Reference selection: {err, word}.
    function automatic logic [W:0] model(logic [N*W-1:0] d, logic [1:0] s);
        int idx;
        idx = int'(s);
        if (idx < N) return {1'b0, d[idx*W +: W]};
        return {1'b1, {W{1'b0}}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, logic [1:0] s, logic [N*W-1:0] d);
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
    endtask

    // Drive an offer and push its expected result if it will be accepted.
    task automatic offer(logic [1:0] s, logic [N*W-1:0] d);
        drive(1'b1, s, d);
        if (bus.in_ready && !rst && !flush) sb_q.push_back(model(d, s));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b1, 2'd0, {3{32'hDEADBEEF}});
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 2'd0, '0);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        vectors++;
        if (bus.out_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_out_data: got %h want 00000000", bus.out_data);
        end
        vectors++;
        if (bus.out_sel_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_sel_err: got %b want 0", bus.out_sel_err);
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_input_lost: out_valid got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_select();
        logic [N*W-1:0] d;
        logic [1:0]     sels[4];
        logic [W:0]     exp;
        d = {32'h33333333, 32'h22222222, 32'h11111111};
        sels[0] = 2'd1; sels[1] = 2'd0; sels[2] = 2'd2; sels[3] = 2'd3;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, sels[i], d);
            exp = model(d, sels[i]);
            tick();
            vectors++;
            if (bus.out_valid !== 1'b1 || {bus.out_sel_err, bus.out_data} !== exp) begin
                miscompares++;
                $display("FAIL select_sel%0d: got v=%b err=%b data=%h want v=1 err=%b data=%h",
                         sels[i], bus.out_valid, bus.out_sel_err, bus.out_data, exp[W], exp[W-1:0]);
            end
        end
        drive(1'b0, 2'd0, '0);
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL select_drain: out_valid got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_stall();
        logic [W:0] exp;
        bus.out_ready = 1'b0;
        offer(2'd0, {32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0});
        tick();
        vectors++;
        if (bus.in_ready !== 1'b1 || {bus.out_sel_err, bus.out_data} !== sb_q[0]) begin
            miscompares++;
            $display("FAIL stall_first: got rdy=%b out=%h want rdy=1 out=%h",
                     bus.in_ready, {bus.out_sel_err, bus.out_data}, sb_q[0]);
        end
        offer(2'd2, {32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0});
        tick();
        drive(1'b0, 2'd0, '0);
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_full_ready: got %b want 0", bus.in_ready);
        end
        tick();
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || {bus.out_sel_err, bus.out_data} !== sb_q[0]) begin
            miscompares++;
            $display("FAIL stall_hold: got v=%b out=%h want v=1 out=%h",
                     bus.out_valid, {bus.out_sel_err, bus.out_data}, sb_q[0]);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp = sb_q.pop_front();
            vectors++;
            if (bus.out_valid !== 1'b1 || {bus.out_sel_err, bus.out_data} !== exp) begin
                miscompares++;
                $display("FAIL stall_drain%0d: got v=%b out=%h want v=1 out=%h",
                         i, bus.out_valid, {bus.out_sel_err, bus.out_data}, exp);
            end
            tick();
            vectors++;
            if (bus.in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_ready_after%0d: got %b want 1", i, bus.in_ready);
            end
        end
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_empty: out_valid got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        offer(2'd1, {3{32'hF00DF00D}});
        tick();
        offer(2'd0, {3{32'hF11DF11D}});
        tick();
        drive(1'b1, 2'd2, {3{32'hCCCCCCCC}});
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 2'd0, '0);
        sb_q.delete();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_full: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        // One entry held, in_ready high: flush must still drop the new input.
        offer(2'd1, {3{32'h12345678}});
        tick();
        drive(1'b1, 2'd0, {3{32'hC2C2C2C2}});
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 2'd0, '0);
        sb_q.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (bus.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_dropped%0d: out_valid got %b want 0", i, bus.out_valid);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [N*W-1:0] d;
        logic [W:0]     exp;
        bus.out_ready = 1'b0;
        offer(2'd2, {3{32'h5A5A5A5A}});
        tick();
        offer(2'd1, {3{32'hA5A5A5A5}});
        tick();
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_full: in_ready got %b want 0", bus.in_ready);
        end
        rst = 1'b1;
        drive(1'b1, 2'd0, {3{32'hEEEEEEEE}});
        tick();
        rst = 1'b0;
        drive(1'b0, 2'd0, '0);
        sb_q.delete();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_state: got v=%b data=%h rdy=%b want v=0 data=00000000 rdy=1",
                     bus.out_valid, bus.out_data, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        d = {32'h0F0F0F0F, 32'h76543210, 32'h01234567};
        drive(1'b1, 2'd1, d);
        exp = model(d, 2'd1);
        tick();
        drive(1'b0, 2'd0, '0);
        vectors++;
        if (bus.out_valid !== 1'b1 || {bus.out_sel_err, bus.out_data} !== exp) begin
            miscompares++;
            $display("FAIL rstmid_first: got v=%b out=%h want v=1 out=%h",
                     bus.out_valid, {bus.out_sel_err, bus.out_data}, exp);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int         accepted = 0;
        int         received = 0;
        int         cycles   = 0;
        logic [W:0] exp;
        while (accepted < 100 && cycles < 2000) begin
            bus.in_valid  = ($urandom_range(0, 9) < 8);
            bus.in_sel    = 2'($urandom_range(0, 3));
            bus.in_data   = {$urandom, $urandom, $urandom};
            bus.out_ready = 1'($urandom_range(0, 1));
            if (bus.out_valid && bus.out_ready) begin
                vectors++;
                received++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_extra: got out=%h want no output", {bus.out_sel_err, bus.out_data});
                end else begin
                    exp = sb_q.pop_front();
                    if ({bus.out_sel_err, bus.out_data} !== exp) begin
                        miscompares++;
                        $display("FAIL b2b_data%0d: got %h want %h", received, {bus.out_sel_err, bus.out_data}, exp);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(model(bus.in_data, bus.in_sel));
                accepted++;
            end
            tick();
            cycles++;
        end
        drive(1'b0, 2'd0, '0);
        bus.out_ready = 1'b1;
        while (sb_q.size() > 0 && cycles < 2000) begin
            if (bus.out_valid) begin
                vectors++;
                received++;
                exp = sb_q.pop_front();
                if ({bus.out_sel_err, bus.out_data} !== exp) begin
                    miscompares++;
                    $display("FAIL b2b_drain%0d: got %h want %h", received, {bus.out_sel_err, bus.out_data}, exp);
                end
            end
            tick();
            cycles++;
        end
        vectors++;
        if (accepted != 100 || received != 100) begin
            miscompares++;
            $display("FAIL b2b_count: got accepted=%0d received=%0d want 100/100", accepted, received);
        end
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_final_empty: out_valid got %b want 0", bus.out_valid);
        end
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 2'd0, '0);
        test_reset();
        test_select();
        test_stall();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit reached want bench completion");
        $fatal(1);
    end

endmodule : tb_pipe_sel_mux
